// File: rtl/flappy_game_ctrl.sv
// Flappy-bird game sequencer: walks the pipe X store through start/stop/ack
// handshakes, paces pipe movement from VGA frame ticks and tracks the best score.
module flappy_game_ctrl #(
    parameter int SPEED_BASE  = 4,
    parameter int HOLD_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       collision,
    input  logic       frame_tick,
    input  logic [3:0] Score,
    input  logic       Q_Initial,
    input  logic       Q_Count,
    input  logic       Q_Stop,
    output logic       Start,
    output logic       Stop,
    output logic       Ack,
    output logic       move_en,
    output logic [1:0] speed_lvl,
    output logic [3:0] high_score,
    output logic       game_over,
    output logic [4:0] ctrl_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_STOPREQ = 3'd3;
    localparam logic [2:0] S_DEAD    = 3'd4;
    localparam logic [2:0] S_ACK     = 3'd5;

    localparam logic [3:0] BASE_PERIOD = 4'(SPEED_BASE);
    localparam logic [7:0] HOLD_LIMIT  = 8'(HOLD_FRAMES);

    logic [2:0] state;
    logic [2:0] state_nx;
    logic [3:0] frame_cnt;
    logic [3:0] period;
    logic [3:0] last_idx;
    logic [7:0] hold_cnt;
    logic       move_tick;
    logic       hold_done;

    assign speed_lvl = Score[3:2];

    always_comb begin
        if (BASE_PERIOD > {2'b00, speed_lvl}) begin
            period = BASE_PERIOD - {2'b00, speed_lvl};
        end else begin
            period = 4'd1;
        end
    end

    // Using >= lets a mid-run speed-up (shorter period) fire on the next tick
    // instead of letting the counter wander past the new end point.
    assign last_idx  = period - 4'd1;
    assign move_tick = (state == S_RUN) && frame_tick && (frame_cnt >= last_idx);
    assign move_en   = move_tick && !collision;
    assign hold_done = (hold_cnt >= HOLD_LIMIT);

    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE:    state_nx = btn_start ? S_LAUNCH : S_IDLE;
            S_LAUNCH:  state_nx = Q_Count ? S_RUN : S_LAUNCH;
            S_RUN:     state_nx = collision ? S_STOPREQ : S_RUN;
            S_STOPREQ: state_nx = Q_Stop ? S_DEAD : S_STOPREQ;
            S_DEAD:    state_nx = (btn_start && hold_done) ? S_ACK : S_DEAD;
            S_ACK:     state_nx = Q_Initial ? S_IDLE : S_ACK;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Requests decode straight from the state so a reset drops them at once.
    always_comb begin
        Start      = 1'b0;
        Stop       = 1'b0;
        Ack        = 1'b0;
        game_over  = 1'b0;
        ctrl_state = 5'b00000;
        case (state)
            S_IDLE:    ctrl_state = 5'b00001;
            S_LAUNCH: begin
                Start      = 1'b1;
                ctrl_state = 5'b00010;
            end
            S_RUN:     ctrl_state = 5'b00010;
            S_STOPREQ: begin
                Stop       = 1'b1;
                ctrl_state = 5'b00100;
            end
            S_DEAD: begin
                game_over  = 1'b1;
                ctrl_state = 5'b01000;
            end
            S_ACK: begin
                Ack        = 1'b1;
                ctrl_state = 5'b10000;
            end
            default:   ctrl_state = 5'b00000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= 4'd0;
        end else if (state != S_RUN) begin
            frame_cnt <= 4'd0;
        end else if (frame_tick) begin
            frame_cnt <= move_tick ? 4'd0 : frame_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= 8'd0;
        end else if (state != S_DEAD) begin
            hold_cnt <= 8'd0;
        end else if (frame_tick && !hold_done) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            high_score <= 4'd0;
        end else if ((state == S_STOPREQ) && Q_Stop && (Score > high_score)) begin
            high_score <= Score;
        end
    end

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: directed game scenarios with literal expectations,
// then randomized play checked every cycle against a phase-level model.
module tb_flappy_game_ctrl;

    localparam int SB = 4;
    localparam int HF = 2;

    localparam int P_IDLE = 0;
    localparam int P_LAUNCH = 1;
    localparam int P_RUN = 2;
    localparam int P_STOPREQ = 3;
    localparam int P_DEAD = 4;
    localparam int P_ACK = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start, collision, frame_tick;
    logic [3:0] Score;
    logic       Q_Initial, Q_Count, Q_Stop;
    logic       Start, Stop, Ack, move_en, game_over;
    logic [1:0] speed_lvl;
    logic [3:0] high_score;
    logic [4:0] ctrl_state;

    int vectors = 0;
    int miscompares = 0;

    int m_phase, m_ticks, m_hold, m_high;

    flappy_game_ctrl #(.SPEED_BASE(SB), .HOLD_FRAMES(HF)) dut (
        .clk(clk), .reset(reset), .btn_start(btn_start), .collision(collision),
        .frame_tick(frame_tick), .Score(Score), .Q_Initial(Q_Initial),
        .Q_Count(Q_Count), .Q_Stop(Q_Stop), .Start(Start), .Stop(Stop), .Ack(Ack),
        .move_en(move_en), .speed_lvl(speed_lvl), .high_score(high_score),
        .game_over(game_over), .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    function automatic int period_of(int s);
        int p;
        p = SB - s / 4;
        return (p < 1) ? 1 : p;
    endfunction

    function automatic int exp_move();
        return (m_phase == P_RUN && frame_tick && !collision &&
                m_ticks + 1 >= period_of(int'(Score))) ? 1 : 0;
    endfunction

    function automatic int exp_ctrl();
        case (m_phase)
            P_IDLE:             return 1;
            P_LAUNCH, P_RUN:    return 2;
            P_STOPREQ:          return 4;
            P_DEAD:             return 8;
            default:            return 16;
        endcase
    endfunction

    task automatic compare(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_ticks = 0;
        m_hold  = 0;
        m_high  = 0;
    endtask

    // Advance the model by one clock using the inputs held across the edge.
    task automatic model_step();
        int mv;
        mv = exp_move();
        case (m_phase)
            P_IDLE:   if (btn_start) m_phase = P_LAUNCH;
            P_LAUNCH: if (Q_Count) begin
                m_phase = P_RUN;
                m_ticks = 0;
            end
            P_RUN: begin
                if (collision) m_phase = P_STOPREQ;
                else if (frame_tick) m_ticks = mv ? 0 : m_ticks + 1;
            end
            P_STOPREQ: if (Q_Stop) begin
                m_phase = P_DEAD;
                m_hold  = 0;
                if (int'(Score) > m_high) m_high = int'(Score);
            end
            P_DEAD: begin
                if (btn_start && m_hold >= HF) m_phase = P_ACK;
                else if (frame_tick && m_hold < HF) m_hold++;
            end
            default: if (Q_Initial) m_phase = P_IDLE;
        endcase
    endtask

    task automatic checkOutput();
        compare("Start", int'(Start), m_phase == P_LAUNCH ? 1 : 0);
        compare("Stop", int'(Stop), m_phase == P_STOPREQ ? 1 : 0);
        compare("Ack", int'(Ack), m_phase == P_ACK ? 1 : 0);
        compare("game_over", int'(game_over), m_phase == P_DEAD ? 1 : 0);
        compare("ctrl_state", int'(ctrl_state), exp_ctrl());
        compare("move_en", int'(move_en), exp_move());
        compare("speed_lvl", int'(speed_lvl), int'(Score) / 4);
        compare("high_score", int'(high_score), m_high);
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic applyStimulus();
        #1;
        checkOutput();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic drive(input bit b, input bit c, input bit f,
                         input bit qi, input bit qc, input bit qs);
        btn_start = b; collision = c; frame_tick = f;
        Q_Initial = qi; Q_Count = qc; Q_Stop = qs;
        applyStimulus();
    endtask

    initial begin
        int start_cycles;
        int pulses;
        reset = 1'b0; btn_start = 0; collision = 0; frame_tick = 0;
        Score = 4'd0; Q_Initial = 0; Q_Count = 0; Q_Stop = 0;
        model_reset();
        @(negedge clk);
        #1;
        compare("rst_ctrl_state", int'(ctrl_state), 1);
        compare("rst_high_score", int'(high_score), 0);
        compare("rst_start", int'(Start), 0);
        applyStimulus();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        // Launch: Start held through three LAUNCH cycles
        drive(1, 0, 0, 0, 0, 0);
        start_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            btn_start = 0; Q_Count = (i == 2);
            #1;
            start_cycles += int'(Start);
            applyStimulus();
        end
        Q_Count = 0;
        #1;
        compare("launch_start_cycles", start_cycles, 3);
        compare("launch_start_low", int'(Start), 0);
        compare("launch_ctrl_run", int'(ctrl_state), 2);

        // Period 4 at Score 0: pulse on every fourth tick
        pulses = 0;
        for (int t = 0; t < 12; t++) begin
            frame_tick = 1;
            #1;
            compare("move_p4", int'(move_en), (t % 4 == 3) ? 1 : 0);
            pulses += int'(move_en);
            applyStimulus();
            drive(0, 0, 0, 0, 0, 0);
        end
        compare("move_p4_count", pulses, 3);

        Score = 4'd12;
        for (int t = 0; t < 4; t++) begin
            frame_tick = 1;
            #1;
            compare("move_p1", int'(move_en), 1);
            applyStimulus();
            drive(0, 0, 0, 0, 0, 0);
        end

        // Collision on a move tick suppresses the move
        frame_tick = 1; collision = 1;
        #1;
        compare("collide_move", int'(move_en), 0);
        applyStimulus();
        frame_tick = 0; collision = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            compare("stop_held", int'(Stop), 1);
            applyStimulus();
        end
        Score = 4'd7;
        drive(0, 0, 0, 0, 0, 1);
        Q_Stop = 0;
        #1;
        compare("dead_high", int'(high_score), 7);
        compare("dead_game_over", int'(game_over), 1);

        // Hold screen: first button press too early, second accepted
        drive(0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        btn_start = 0;
        #1;
        compare("early_btn_ignored", int'(ctrl_state), 8);
        drive(0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        btn_start = 0;
        #1;
        compare("ack_state", int'(ctrl_state), 16);
        compare("ack_high", int'(Ack), 1);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        Q_Initial = 0;
        #1;
        compare("back_idle", int'(ctrl_state), 1);

        // Second game scoring lower keeps the best score
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0);
        Score = 4'd5;
        drive(0, 0, 0, 0, 0, 1);
        Q_Stop = 0;
        #1;
        compare("game2_high", int'(high_score), 7);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);

        // Asynchronous reset in the middle of the stop handshake
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0);
        collision = 0;
        #1;
        compare("pre_reset_stop", int'(Stop), 1);
        reset = 1'b0;
        model_reset();
        #1;
        compare("areset_stop", int'(Stop), 0);
        compare("areset_ctrl", int'(ctrl_state), 1);
        compare("areset_high", int'(high_score), 0);
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        compare("post_reset_start", int'(Start), 0);

        // Randomized play against the model
        for (int n = 0; n < 4000; n++) begin
            btn_start  = ($urandom_range(0, 5) == 0);
            collision  = ($urandom_range(0, 11) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            Q_Initial  = ($urandom_range(0, 3) == 0);
            Q_Count    = ($urandom_range(0, 3) == 0);
            Q_Stop     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) Score = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                model_reset();
            end else begin
                reset = 1'b1;
            end
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
